// File: rtl/keyb_if.sv
// Keypad scanner bus.
// Carries the keypad matrix lines (row_in in, col_drv out) and the decoded
// key event (key_valid pulse, key_held level, btn_id and class fields).
// master : the scanner (reads row_in, drives everything else)
// slave  : the keypad/consumer side
interface keyb_if #(
  parameter int N_COLS = 4,
  parameter int N_ROWS = 4
) ();
  logic [N_ROWS-1:0]        row_in;
  logic [N_COLS-1:0]        col_drv;
  logic                     key_valid;
  logic                     key_held;
  logic [N_COLS+N_ROWS-1:0] btn_id;
  logic                     is_number;
  logic                     is_op;
  logic                     is_eq;
  logic                     is_clr;
  logic [3:0]               num_val;
  logic [1:0]               op_val;

  modport master (
    input  row_in,
    output col_drv, key_valid, key_held, btn_id,
           is_number, is_op, is_eq, is_clr, num_val, op_val
  );

  modport slave (
    output row_in,
    input  col_drv, key_valid, key_held, btn_id,
           is_number, is_op, is_eq, is_clr, num_val, op_val
  );
endinterface

// File: rtl/keyb_scanner.sv
// Matrix keypad scanner and decoder.
// Drives one column at a time for SCAN_DIV cycles, samples the synchronised
// rows on the last dwell cycle, debounces a single-row hit for DEBOUNCE_CNT
// cycles, then emits one key_valid pulse with registered btn_id and class
// fields. key_held stays high until release has been stable for
// DEBOUNCE_CNT cycles.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - keyb_if master: row_in in; col_drv, key_valid, key_held, btn_id,
//          is_number, is_op, is_eq, is_clr, num_val, op_val out
module keyb_scanner #(
  parameter int N_COLS       = 4,
  parameter int N_ROWS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic   clk,
  input  logic   rst,
  keyb_if.master bus
);
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CNT);
  localparam int IW = N_COLS + N_ROWS;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] CNT_LAST   = BW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(N_COLS - 1);
  localparam bit DECODE_EN = (N_COLS == 4) && (N_ROWS == 4);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t            state, state_n;
  logic [N_ROWS-1:0] row_meta, row_sync;
  logic [N_ROWS-1:0] row_cap, row_cap_n;
  logic [CW-1:0]     col_idx, col_n;
  logic [DW-1:0]     dwell, dwell_n;
  logic [BW-1:0]     cnt, cnt_n;
  logic              held_n;
  logic              load;
  logic [N_COLS-1:0] col_drv_n;
  logic [IW-1:0]     id_n;
  logic [9:0]        cls_n;

  function automatic logic [CW-1:0] next_col(input logic [CW-1:0] c);
    return (c == COL_LAST) ? '0 : c + CW'(1);
  endfunction

  // {col field, row field}; column c -> bit N_COLS-1-c of the col field,
  // row r -> bit N_ROWS-1-r of the row field.
  function automatic logic [IW-1:0] make_id(input logic [CW-1:0] c,
                                            input logic [N_ROWS-1:0] rows);
    logic [IW-1:0] id;
    id = '0;
    for (int i = 0; i < N_COLS; i++) id[IW-1-i] = (c == CW'(i));
    for (int i = 0; i < N_ROWS; i++) id[N_ROWS-1-i] = rows[i];
    return id;
  endfunction

  // Returns {is_number, is_op, is_eq, is_clr, num_val[3:0], op_val[1:0]}.
  // Indexed by col*4 + row for the 4x4 calculator layout.
  function automatic logic [9:0] decode_key(input logic [CW-1:0] c,
                                            input logic [N_ROWS-1:0] rows);
    int r;
    int key;
    logic [9:0] f;
    r = 0;
    for (int i = 0; i < N_ROWS; i++) if (rows[i]) r = i;
    key = int'(c) * 4 + r;
    f = '0;
    if (DECODE_EN) begin
      case (key)
        0:       f = {4'b1000, 4'd1, 2'd0};
        1:       f = {4'b1000, 4'd4, 2'd0};
        2:       f = {4'b1000, 4'd7, 2'd0};
        3:       f = {4'b0001, 4'd0, 2'd0};
        4:       f = {4'b1000, 4'd2, 2'd0};
        5:       f = {4'b1000, 4'd5, 2'd0};
        6:       f = {4'b1000, 4'd8, 2'd0};
        7:       f = {4'b1000, 4'd0, 2'd0};
        8:       f = {4'b1000, 4'd3, 2'd0};
        9:       f = {4'b1000, 4'd6, 2'd0};
        10:      f = {4'b1000, 4'd9, 2'd0};
        12:      f = {4'b0100, 4'd0, 2'd1};
        13:      f = {4'b0100, 4'd0, 2'd2};
        14:      f = {4'b0100, 4'd0, 2'd3};
        15:      f = {4'b0010, 4'd0, 2'd0};
        default: f = '0;
      endcase
    end
    return f;
  endfunction

  // Row synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= bus.row_in;
      row_sync <= row_meta;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_n   = state;
    col_n     = col_idx;
    dwell_n   = dwell;
    cnt_n     = cnt;
    row_cap_n = row_cap;
    held_n    = bus.key_held;
    load      = 1'b0;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_n = '0;
          if ($onehot(row_sync)) begin
            row_cap_n = row_sync;
            cnt_n     = '0;
            state_n   = DEBOUNCE;
          end else begin
            // nothing pressed, or ghosting across rows: move on
            col_n = next_col(col_idx);
          end
        end else begin
          dwell_n = dwell + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (row_sync != row_cap) begin
          // bounce: rescan the same column from a fresh dwell
          state_n = SCAN;
          dwell_n = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = HELD;
          cnt_n   = '0;
          held_n  = 1'b1;
          load    = 1'b1;
        end else begin
          cnt_n = cnt + BW'(1);
        end
      end
      HELD: begin
        // any row in the driven column (not just the captured one) keeps it held
        if (row_sync != '0) begin
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = SCAN;
          held_n  = 1'b0;
          col_n   = next_col(col_idx);
          dwell_n = '0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + BW'(1);
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_comb begin
    col_drv_n        = '0;
    col_drv_n[col_n] = 1'b1;
  end

  assign id_n  = make_id(col_idx, row_cap);
  assign cls_n = decode_key(col_idx, row_cap);

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SCAN;
      col_idx       <= '0;
      dwell         <= '0;
      cnt           <= '0;
      row_cap       <= '0;
      bus.col_drv   <= N_COLS'(1);
      bus.key_valid <= 1'b0;
      bus.key_held  <= 1'b0;
      bus.btn_id    <= '0;
      bus.is_number <= 1'b0;
      bus.is_op     <= 1'b0;
      bus.is_eq     <= 1'b0;
      bus.is_clr    <= 1'b0;
      bus.num_val   <= '0;
      bus.op_val    <= '0;
    end else begin
      state         <= state_n;
      col_idx       <= col_n;
      dwell         <= dwell_n;
      cnt           <= cnt_n;
      row_cap       <= row_cap_n;
      bus.col_drv   <= col_drv_n;
      bus.key_valid <= load;
      bus.key_held  <= held_n;
      if (load) begin
        bus.btn_id    <= id_n;
        bus.is_number <= cls_n[9];
        bus.is_op     <= cls_n[8];
        bus.is_eq     <= cls_n[7];
        bus.is_clr    <= cls_n[6];
        bus.num_val   <= cls_n[5:2];
        bus.op_val    <= cls_n[1:0];
      end
    end
  end
endmodule

// File: tb/tb_keyb_scanner.sv
// Self-checking bench for keyb_scanner (4x4, SCAN_DIV=4, DEBOUNCE_CNT=8).
// A keypad model closes the loop: row r reads high when a pressed key in
// row r sits in a driven column.
module tb_keyb_scanner;
  localparam int NC = 4;
  localparam int NR = 4;
  localparam int SD = 4;
  localparam int DB = 8;
  localparam int LAT_MIN = DB + 3;
  localparam int LAT_MAX = NC * SD + DB + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NC*NR-1:0] pressed = '0;
  int checks = 0;
  int errors = 0;

  keyb_if #(.N_COLS(NC), .N_ROWS(NR)) kb ();

  keyb_scanner #(
    .N_COLS(NC), .N_ROWS(NR), .SCAN_DIV(SD), .DEBOUNCE_CNT(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(kb)
  );

  always #5 clk = ~clk;

  always_comb begin
    kb.row_in = '0;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++)
        if (pressed[c*NR+r] && kb.col_drv[c]) kb.row_in[r] = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode: {14'b0, btn_id, is_number, is_op, is_eq, is_clr, num_val, op_val}
  function automatic logic [31:0] exp_fields(input int c, input int r);
    logic [7:0] id;
    logic num, op, eq, clr;
    logic [3:0] nv;
    logic [1:0] ov;
    id = 8'((1 << (7 - c)) | (1 << (3 - r)));
    num = 0; op = 0; eq = 0; clr = 0; nv = 0; ov = 0;
    if (c < 3 && r < 3) begin
      num = 1; nv = 4'(3 * r + c + 1);
    end else if (c == 1 && r == 3) begin
      num = 1; nv = 4'd0;
    end else if (c == 3 && r < 3) begin
      op = 1; ov = 2'(r + 1);
    end else if (c == 3 && r == 3) begin
      eq = 1;
    end else if (c == 0 && r == 3) begin
      clr = 1;
    end
    return {14'd0, id, num, op, eq, clr, nv, ov};
  endfunction

  function automatic logic [31:0] got_fields();
    return {14'd0, kb.btn_id, kb.is_number, kb.is_op, kb.is_eq, kb.is_clr,
            kb.num_val, kb.op_val};
  endfunction

  // Call just after a negedge; returns at the negedge where rst drops.
  task automatic reset_dut(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_col"}, 32'(kb.col_drv), 32'h1);
    chk({tag, "_outs"}, {kb.key_valid, kb.key_held, got_fields()}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (kb.key_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_fall(input int bound, output int n);
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (!kb.key_held) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic step_count(input int n, output int pulses, output int held_lo);
    pulses = 0;
    held_lo = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (kb.key_valid) pulses++;
      if (!kb.key_held) held_lo++;
    end
  endtask

  // Press one key from reset and check exact latency plus decode.
  task automatic press_from_reset(input string tag, input int c, input int r);
    int lat;
    pressed = '0;
    pressed[c*NR+r] = 1'b1;
    reset_dut({tag, "_rst"});
    wait_valid(60, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(4 * c + 4 + DB));
    chk({tag, "_fields"}, got_fields(), exp_fields(c, r));
  endtask

  initial begin
    int lat, n, p, h, trans, bad;
    int c, r, oc, orr, blen;
    logic [NC-1:0] prev;

    @(negedge clk);

    // Idle rotation after reset
    reset_dut("rst0");
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      chk("rotate", 32'(kb.col_drv), 32'(1 << ((k / 4) % 4)));
    end

    // Key 5: single pulse, long hold, other row in same column, release
    press_from_reset("k5", 1, 1);
    step_count(1, p, h);
    chk("k5_pulse", {30'd0, kb.key_valid, kb.key_held}, 32'b01);
    step_count(200, p, h);
    chk("k5_hold_pulses", 32'(p), 0);
    chk("k5_hold_held", 32'(h), 0);
    pressed = '0;
    pressed[1*NR+2] = 1'b1;
    step_count(6, p, h);
    chk("k5_samecol", 32'(p + h), 0);
    pressed = '0;
    wait_fall(40, n);
    chk("k5_release", 32'(n), 32'(DB + 2));
    chk("k5_coladv", 32'(kb.col_drv), 32'b0100);
    chk("k5_keep", got_fields(), exp_fields(1, 1));

    // Key 5 bouncing, then stable
    pressed = '0;
    reset_dut("bnc_rst");
    p = 0;
    for (int i = 0; i < 30; i++) begin
      pressed[1*NR+1] = ((i / 3) % 2 == 0);
      @(negedge clk);
      if (kb.key_valid) p++;
    end
    chk("bnc_quiet", 32'(p), 0);
    pressed[1*NR+1] = 1'b1;
    wait_valid(LAT_MAX, lat);
    chk("bnc_lat", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
    chk("bnc_fields", got_fields(), exp_fields(1, 1));
    step_count(50, p, h);
    chk("bnc_single", 32'(p), 0);

    // Keys 1 and 4 together: ghosting, scan keeps rotating
    pressed = '0;
    pressed[0*NR+0] = 1'b1;
    pressed[0*NR+1] = 1'b1;
    reset_dut("gh_rst");
    p = 0; trans = 0; bad = 0;
    prev = kb.col_drv;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (kb.key_valid) p++;
      if (kb.col_drv != prev) trans++;
      if (!$onehot(kb.col_drv)) bad++;
      prev = kb.col_drv;
    end
    chk("ghost_pulses", 32'(p), 0);
    chk("ghost_trans", 32'(trans), 16);
    chk("ghost_onehot", 32'(bad), 0);

    // Operator, equals, clear
    press_from_reset("mul", 3, 2);
    press_from_reset("eq", 3, 3);
    press_from_reset("clr", 0, 3);

    // Reset 4 cycles into debounce of key 9
    pressed = '0;
    pressed[2*NR+2] = 1'b1;
    reset_dut("k9_rst");
    step_count(16, p, h);
    chk("k9_pre", 32'(p), 0);
    reset_dut("k9_mid");
    wait_valid(60, lat);
    chk("k9_lat", 32'(lat), 32'(4 * 2 + 4 + DB));
    chk("k9_fields", got_fields(), exp_fields(2, 2));

    // Randomised presses against the reference decode and timing rules
    pressed = '0;
    reset_dut("rnd_rst");
    step_count(5, p, h);
    for (int it = 0; it < 24; it++) begin
      c = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        blen = 6 * $urandom_range(1, 3);
        p = 0;
        for (int i = 0; i < blen; i++) begin
          pressed[c*NR+r] = ((i / 3) % 2 == 0);
          @(negedge clk);
          if (kb.key_valid) p++;
        end
        chk("rnd_bounce", 32'(p), 0);
      end
      pressed[c*NR+r] = 1'b1;
      wait_valid(LAT_MAX, lat);
      chk("rnd_lat", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
      chk("rnd_fields", got_fields(), exp_fields(c, r));
      if ($urandom_range(0, 1) == 1) begin
        oc  = (c + 1 + $urandom_range(0, 2)) % 4;
        orr = $urandom_range(0, 3);
        pressed[oc*NR+orr] = 1'b1;
      end
      step_count($urandom_range(10, 50), p, h);
      chk("rnd_hold", 32'(p + h), 0);
      pressed = '0;
      wait_fall(40, n);
      chk("rnd_release", 32'(n), 32'(DB + 2));
      step_count($urandom_range(3, 12), p, h);
      chk("rnd_idle", 32'(p), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keyb_scanner.md
# keyb_scanner

Parametrised matrix-keypad scanner and decoder for the calculator front end. It drives keypad columns one at a time and samples the rows through a synchroniser. Each new keypress is debounced before release, and the block emits one `key_valid` pulse per press together with a registered key ID and decoded class fields. In the default 4x4 configuration it adds multiply and clear keys to the digit, plus, minus and equals set.

## Interface
Parameters:
- `N_COLS`, 4: keypad columns, ≥1.
- `N_ROWS`, 4: keypad rows, ≥1.
- `SCAN_DIV`, 1000: clock cycles each column is driven during scanning, ≥4.
- `DEBOUNCE_CNT`, 20000: consecutive stable cycles required for press and for release, ≥2.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `row_in`  in  N_ROWS  raw row lines, active-high, asynchronous to `clk`.
- `col_drv`  out  N_COLS  one-hot column drive; `col_drv[c]` drives column c.
- `key_valid`  out  1  one-cycle pulse per accepted press.
- `key_held`  out  1  high from the `key_valid` cycle until release is debounced.
- `btn_id`  out  N_COLS+N_ROWS  `{col field, row field}`. Column c sets col-field bit N_COLS-1-c; row r sets row-field bit N_ROWS-1-r.
- `is_number`, `is_op`, `is_eq`, `is_clr`  out  1 each  key class.
- `num_val`  out  4  digit value.
- `op_val`  out  2  operator: 1 = plus, 2 = minus, 3 = multiply.

## Operation
- Reset behaviour: `row_in` passes through 2 flops (`row_sync`), and these reset to 0.
- All outputs are registered and reset to 0, except `col_drv`, which resets to 1 (column 0).
- FSM states are SCAN, DEBOUNCE and HELD; the reset state is SCAN with column index 0.
- SCAN:
  - Drive the current column for SCAN_DIV cycles.
  - On the last dwell cycle, check `row_sync`:
    - Exactly one bit set: capture the column index and `row_sync`, and enter DEBOUNCE on the next cycle with the column unchanged.
    - Zero, or more than one bit set (ghosting): advance the column. Index N_COLS-1 wraps to 0.
- DEBOUNCE:
  - The counter starts at 0 on entry and increments on each cycle where `row_sync` equals the captured row.
  - Any mismatch returns the FSM to SCAN at the same column with the dwell counter cleared. No outputs change.
  - The FSM enters HELD on the cycle after the counter reaches DEBOUNCE_CNT-1 with a match.
- HELD, entry cycle:
  - `key_valid` = 1 for this cycle only, and `key_held` = 1.
  - `btn_id` and the class fields load.
- HELD, waiting for release:
  - The release counter increments while `row_sync` == 0.
  - Any nonzero `row_sync` clears the counter; this includes another row in the same column.
  - When the counter reaches DEBOUNCE_CNT-1: `key_held` = 0, return to SCAN, and advance the column.
- No auto-repeat. Keys in other columns are invisible while in HELD.
- `btn_id` and the class fields hold their values until the next `key_valid`.
- Decode applies only when N_COLS = 4 and N_ROWS = 4; otherwise all class fields stay 0 and only `btn_id` is meaningful. Keys by (col,row):
  - Digits, `is_number`=1 with `num_val`: (0,0)=1, (1,0)=2, (2,0)=3, (0,1)=4, (1,1)=5, (2,1)=6, (0,2)=7, (1,2)=8, (2,2)=9, (1,3)=0.
  - Operators, `is_op`=1 with `op_val`: (3,0)=1, (3,1)=2, (3,2)=3.
  - (3,3): `is_eq`=1.
  - (0,3): `is_clr`=1.
  - (2,3): no class set, but still pulses `key_valid`.
- Unused value fields are 0: `num_val` is 0 for non-digits, `op_val` is 0 for non-operators.
- Exactly one class flag is high, or none.

## Timing
- Synchroniser latency is 2 cycles from `row_in` to `row_sync`.
- Detection latency: up to N_COLS·SCAN_DIV + 2 cycles from a stable press to DEBOUNCE entry.
- `key_valid` asserts exactly DEBOUNCE_CNT cycles after DEBOUNCE entry if the row stays stable.
- Release latency: `key_held` falls DEBOUNCE_CNT cycles after `row_sync` first goes 0 and stays 0.
- Reset mid-operation: all state and outputs return to reset values immediately (asynchronously). Nothing partially debounced survives.
- Counter widths are `$clog2` of their maximum value. Counters never exceed their terminal values and wrap only through state change.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=8.
- Reset with `row_in`=0: all outputs 0 and `col_drv`=4'b0001; after release `col_drv` rotates 0001→0010→0100→1000→0001, 4 cycles per step.
- Hold key 5 (`row_in`[1] high whenever `col_drv`[1]): one `key_valid` pulse with `btn_id`=8'b0100_0100, `is_number`=1, `num_val`=5. No further pulse for 200 held cycles. `key_held` falls 8 cycles after `row_sync` clears.
- Key 5 bounces (toggling every 3 cycles for 30 cycles), then stays stable: exactly one `key_valid`, no pulse during the bounce.
- Keys 1 and 4 held together (column 0, rows 0 and 1): no `key_valid`, and `col_drv` keeps rotating.
- Multiply (3,2): `btn_id`=8'b0001_0010, `is_op`=1, `op_val`=3. Equals (3,3): `btn_id`=8'b0001_0001, `is_eq`=1. Clear (0,3): `btn_id`=8'b1000_0001, `is_clr`=1.
- Assert `rst` for 1 cycle, 4 cycles into DEBOUNCE of key 9: outputs are 0 and `col_drv`=0001 that cycle. A fresh scan plus full debounce is then required before any `key_valid`.
